// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences PC/IR, ALU, register file and memory
// with memory wait states, a wait timeout, sticky error flags and a retire counter.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             i_or_d,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_IMMEX  = 4'd8;
    localparam logic [3:0] S_ALUWB  = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_ERR    = 4'd12;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // wait_cnt only has to reach TIMEOUT-1 before the FSM traps
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [WCW-1:0] WLAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             done;
    logic             mem_st;
    logic             stall;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        instr_cnt_d = instr_cnt_q;
        wait_cnt_d  = '0;
        done        = 1'b0;
        mem_st      = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_st = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = op;
                case (op)
                    OP_R:      state_d = S_EXEC;
                    OP_LW,
                    OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:    state_d = S_BRANCH;
                    OP_J:      state_d = S_JUMP;
                    OP_ADDI,
                    OP_ADDIU,
                    OP_ORI,
                    OP_LUI:    state_d = S_IMMEX;
                    default: begin
                        state_d   = S_ERR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                mem_st = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:  done = 1'b1;
            S_MEMWR: begin
                mem_st = 1'b1;
                done   = mem_ready;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_ALUWB;
            S_ALUWB:  done = 1'b1;
            S_BRANCH: done = 1'b1;
            S_JUMP:   done = 1'b1;
            default:  state_d = S_ERR;
        endcase

        if (done) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
            state_d     = run ? S_FETCH : S_IDLE;
        end

        stall = mem_st && !mem_ready;
        if (TO_EN && stall) begin
            if (wait_cnt_q == WLAST) begin
                state_d   = S_ERR;
                bus_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wait_cnt_q  <= '0;
            instr_cnt_q <= '0;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            illegal_q   <= illegal_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        i_or_d     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_op     = 3'b000;
        case (state_q)
            S_FETCH: begin
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                i_or_d = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ADDI,
                    OP_ADDIU: ext_op = 1'b1;
                    OP_ORI:   alu_op = 3'b010;
                    OP_LUI:   alu_op = 3'b111;
                    default:  alu_op = 3'b000;
                endcase
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = (op_q == OP_R);
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b100;
                pc_src    = 2'b01;
                pc_we     = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table plus
// hand-built sequences for illegal opcode, memory timeout and async reset.
module tb_multicycle_ctrl;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [5:0]    op = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_we, ir_we, i_or_d, mem_re, mem_we;
    logic          reg_we, reg_dst, mem_to_reg, alu_src_a, ext_op;
    logic [1:0]    pc_src, alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic          illegal, bus_err;
    logic [CW-1:0] instr_cnt;
    logic [16:0]   act_ctl;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src),
        .ir_we(ir_we), .i_or_d(i_or_d), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .alu_op(alu_op), .state(state), .illegal(illegal),
        .bus_err(bus_err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign act_ctl = {pc_we, pc_src, ir_we, i_or_d, mem_re, mem_we, reg_we,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op};

    // {pc_we,pc_src,ir_we,i_or_d,mem_re,mem_we,reg_we,reg_dst,mem_to_reg,src_a,src_b,ext_op,alu_op}
    localparam logic [16:0] C_Z   = 17'b0_00_0_0_0_0_0_0_0_0_00_0_000;
    localparam logic [16:0] C_FR  = 17'b1_00_1_0_1_0_0_0_0_0_01_0_000;
    localparam logic [16:0] C_FW  = 17'b0_00_0_0_1_0_0_0_0_0_01_0_000;
    localparam logic [16:0] C_DEC = 17'b0_00_0_0_0_0_0_0_0_0_11_1_000;
    localparam logic [16:0] C_MA  = 17'b0_00_0_0_0_0_0_0_0_1_10_1_000;
    localparam logic [16:0] C_MRD = 17'b0_00_0_1_1_0_0_0_0_0_00_0_000;
    localparam logic [16:0] C_MWB = 17'b0_00_0_0_0_0_1_0_1_0_00_0_000;
    localparam logic [16:0] C_MWR = 17'b0_00_0_1_0_1_0_0_0_0_00_0_000;
    localparam logic [16:0] C_EX  = 17'b0_00_0_0_0_0_0_0_0_1_00_0_001;
    localparam logic [16:0] C_ADI = 17'b0_00_0_0_0_0_0_0_0_1_10_1_000;
    localparam logic [16:0] C_ORI = 17'b0_00_0_0_0_0_0_0_0_1_10_0_010;
    localparam logic [16:0] C_LUI = 17'b0_00_0_0_0_0_0_0_0_1_10_0_111;
    localparam logic [16:0] C_WBR = 17'b0_00_0_0_0_0_1_1_0_0_00_0_000;
    localparam logic [16:0] C_WBI = 17'b0_00_0_0_0_0_1_0_0_0_00_0_000;
    localparam logic [16:0] C_BR1 = 17'b1_01_0_0_0_0_0_0_0_1_00_0_100;
    localparam logic [16:0] C_BR0 = 17'b0_01_0_0_0_0_0_0_0_1_00_0_100;
    localparam logic [16:0] C_J   = 17'b1_10_0_0_0_0_0_0_0_0_00_0_000;

    localparam logic [5:0] XX = 6'h3F;

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        int          cnt;
        logic        ill;
        logic        be;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] ctl;
        int          cnt;
        logic        ill;
        logic        be;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    function automatic vec_t v(logic r, logic [5:0] o, logic z, logic rd,
                               logic [3:0] s, logic [16:0] c, int n,
                               logic il = 1'b0, logic b = 1'b0);
        vec_t t;
        t.run = r; t.op = o; t.zero = z; t.rdy = rd;
        t.st = s; t.ctl = c; t.cnt = n; t.ill = il; t.be = b;
        return t;
    endfunction

    task automatic push_exp(input string nm, input vec_t t);
        exp_t e;
        e.name = nm; e.st = t.st; e.ctl = t.ctl;
        e.cnt = t.cnt; e.ill = t.ill; e.be = t.be;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
            return;
        end
        e = sbq.pop_front();
        checks++;
        if (state !== e.st || act_ctl !== e.ctl || illegal !== e.ill ||
            bus_err !== e.be || instr_cnt !== CW'(e.cnt)) begin
            errors++;
            $display("FAIL %s: got st=%0d ctl=%b ill=%b be=%b cnt=%0d want st=%0d ctl=%b ill=%b be=%b cnt=%0d",
                     e.name, state, act_ctl, illegal, bus_err, instr_cnt,
                     e.st, e.ctl, e.ill, e.be, e.cnt);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        run = t.run; op = t.op; zero = t.zero; mem_ready = t.rdy;
        push_exp(nm, t);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        push_exp("reset", v(0, XX, 0, 0, 4'd0, C_Z, 0));
        pop_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        // R-type, zero-wait
        tbl.push_back(v(1, XX, 0, 1, 4'd0, C_Z,   0));
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  0));
        tbl.push_back(v(1, 6'b000000, 0, 1, 4'd2, C_DEC, 0));
        tbl.push_back(v(1, XX, 0, 1, 4'd7, C_EX,  0));
        tbl.push_back(v(1, XX, 0, 1, 4'd9, C_WBR, 0));
        // lw with three wait states in MEMRD
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  1));
        tbl.push_back(v(1, 6'b100011, 0, 1, 4'd2, C_DEC, 1));
        tbl.push_back(v(1, XX, 0, 1, 4'd3, C_MA,  1));
        tbl.push_back(v(1, XX, 0, 0, 4'd4, C_MRD, 1));
        tbl.push_back(v(1, XX, 0, 0, 4'd4, C_MRD, 1));
        tbl.push_back(v(1, XX, 0, 0, 4'd4, C_MRD, 1));
        tbl.push_back(v(1, XX, 0, 1, 4'd4, C_MRD, 1));
        tbl.push_back(v(1, XX, 0, 1, 4'd5, C_MWB, 1));
        // beq taken, then not taken
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  2));
        tbl.push_back(v(1, 6'b000100, 0, 1, 4'd2, C_DEC, 2));
        tbl.push_back(v(1, XX, 1, 1, 4'd10, C_BR1, 2));
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  3));
        tbl.push_back(v(1, 6'b000100, 0, 1, 4'd2, C_DEC, 3));
        tbl.push_back(v(1, XX, 0, 1, 4'd10, C_BR0, 3));
        // ori, lui, addi
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  4));
        tbl.push_back(v(1, 6'b001101, 0, 1, 4'd2, C_DEC, 4));
        tbl.push_back(v(1, XX, 0, 1, 4'd8, C_ORI, 4));
        tbl.push_back(v(1, XX, 0, 1, 4'd9, C_WBI, 4));
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  5));
        tbl.push_back(v(1, 6'b001111, 0, 1, 4'd2, C_DEC, 5));
        tbl.push_back(v(1, XX, 0, 1, 4'd8, C_LUI, 5));
        tbl.push_back(v(1, XX, 0, 1, 4'd9, C_WBI, 5));
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  6));
        tbl.push_back(v(1, 6'b001000, 0, 1, 4'd2, C_DEC, 6));
        tbl.push_back(v(1, XX, 0, 1, 4'd8, C_ADI, 6));
        tbl.push_back(v(1, XX, 0, 1, 4'd9, C_WBI, 6));
        // j with run dropped: returns to idle
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  7));
        tbl.push_back(v(1, 6'b000010, 0, 1, 4'd2, C_DEC, 7));
        tbl.push_back(v(0, XX, 0, 1, 4'd11, C_J,  7));
        tbl.push_back(v(0, XX, 0, 1, 4'd0, C_Z,   8));
        tbl.push_back(v(0, XX, 0, 1, 4'd0, C_Z,   8));
        // sw with a fetch wait and run low mid-instruction
        tbl.push_back(v(1, XX, 0, 1, 4'd0, C_Z,   8));
        tbl.push_back(v(1, XX, 0, 0, 4'd1, C_FW,  8));
        tbl.push_back(v(1, XX, 0, 1, 4'd1, C_FR,  8));
        tbl.push_back(v(0, 6'b101011, 0, 1, 4'd2, C_DEC, 8));
        tbl.push_back(v(0, XX, 0, 1, 4'd3, C_MA,  8));
        tbl.push_back(v(0, XX, 0, 0, 4'd6, C_MWR, 8));
        tbl.push_back(v(0, XX, 0, 1, 4'd6, C_MWR, 8));
        tbl.push_back(v(0, XX, 0, 1, 4'd0, C_Z,   9));

        run = 1'b1;
        mem_ready = 1'b1;
        #2;
        do_reset();

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // illegal opcode traps until reset
        apply(v(1, XX, 0, 1, 4'd0, C_Z,   9), "ill_idle");
        apply(v(1, XX, 0, 1, 4'd1, C_FR,  9), "ill_fetch");
        apply(v(1, 6'b111111, 0, 1, 4'd2, C_DEC, 9), "ill_decode");
        for (int k = 0; k < 3; k++)
            apply(v(1, 6'b000000, 1, 1, 4'd12, C_Z, 9, 1'b1), $sformatf("ill_err%0d", k));
        do_reset();

        // fetch timeout after exactly 16 stalled cycles
        apply(v(1, XX, 0, 0, 4'd0, C_Z, 0), "to_idle");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (state != 4'd1) break;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_len: got %0d fetch cycles want 16", n);
        end
        push_exp("to_err", v(1, XX, 0, 0, 4'd12, C_Z, 0, 1'b0, 1'b1));
        pop_check();
        @(posedge clk);
        #1;
        do_reset();

        // asynchronous reset while a store is stalled
        apply(v(1, XX, 0, 1, 4'd0, C_Z,   0), "rs_idle");
        apply(v(1, XX, 0, 1, 4'd1, C_FR,  0), "rs_fetch");
        apply(v(1, 6'b000000, 0, 1, 4'd2, C_DEC, 0), "rs_dec");
        apply(v(1, XX, 0, 1, 4'd7, C_EX,  0), "rs_exec");
        apply(v(1, XX, 0, 1, 4'd9, C_WBR, 0), "rs_wb");
        apply(v(1, XX, 0, 1, 4'd1, C_FR,  1), "rs_fetch2");
        apply(v(1, 6'b101011, 0, 1, 4'd2, C_DEC, 1), "rs_dec2");
        apply(v(1, XX, 0, 1, 4'd3, C_MA,  1), "rs_ma");
        apply(v(1, XX, 0, 0, 4'd6, C_MWR, 1), "rs_mwr");
        push_exp("rs_mwr_hold", v(1, XX, 0, 0, 4'd6, C_MWR, 1));
        pop_check();
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("rs_async", v(1, XX, 0, 0, 4'd0, C_Z, 0));
        pop_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
